// File: rtl/pwd_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwd_mem_ctrl: arbiter/sequencer for the 4x16 lock code memory, with        |
// | per-slot valid bits and consecutive-failure lockout.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwd_mem_ctrl #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned LOCK_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_req,
  input  logic [1:0]  prog_slot,
  input  logic [15:0] prog_code,
  input  logic        prog_clr,
  output logic        prog_done,
  input  logic        ver_req,
  input  logic [15:0] ver_code,
  output logic        ver_done,
  output logic        ver_match,
  output logic [1:0]  ver_slot,
  output logic        locked,
  output logic [1:0]  mem_idx,
  output logic        mem_wr,
  output logic        mem_en,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_SCAN  = 3'd2,
    S_ACK_P = 3'd3,
    S_ACK_V = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_slot;
  logic [15:0]       r_code;
  logic              r_clr;
  logic [1:0]        r_idx;
  logic [3:0]        r_valid;
  logic [3:0]        r_fail;
  logic [LOCK_W-1:0] r_lock;
  logic              r_match;
  logic [1:0]        r_mslot;

  logic              w_locked;
  logic              w_hit;
  logic              w_last;
  logic [3:0]        w_fail_inc;
  logic              w_lock_load;

  assign w_locked    = (r_lock != '0);
  assign w_hit       = r_valid[r_idx] & (mem_rdata == r_code);
  assign w_last      = (r_idx == 2'd3);
  assign w_fail_inc  = r_fail + 4'd1;
  assign w_lock_load = (r_state == S_SCAN) && !w_hit && w_last &&
                       (w_fail_inc == 4'(MAX_FAIL));
  assign locked      = w_locked;

  // Outputs are decoded from the state alone; captured request fields feed them.
  always_comb begin
    w_state_nxt = r_state;
    prog_done   = 1'b0;
    ver_done    = 1'b0;
    ver_match   = 1'b0;
    ver_slot    = 2'd0;
    mem_idx     = 2'd0;
    mem_wr      = 1'b0;
    mem_en      = 1'b0;
    mem_wdata   = 16'd0;
    case (r_state)
      S_IDLE: begin
        if (prog_req)
          w_state_nxt = S_PROG;
        else if (ver_req && !w_locked)
          w_state_nxt = S_SCAN;
      end
      S_PROG: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_idx     = r_slot;
        mem_wdata   = r_clr ? 16'd0 : r_code;
        w_state_nxt = S_ACK_P;
      end
      S_SCAN: begin
        mem_en  = 1'b1;
        mem_idx = r_idx;
        if (w_hit || w_last)
          w_state_nxt = S_ACK_V;
      end
      S_ACK_P: begin
        prog_done = 1'b1;
        if (!prog_req)
          w_state_nxt = S_IDLE;
      end
      S_ACK_V: begin
        ver_done  = 1'b1;
        ver_match = r_match;
        ver_slot  = r_match ? r_mslot : 2'd0;
        if (!ver_req)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_slot  <= 2'd0;
      r_code  <= 16'd0;
      r_clr   <= 1'b0;
      r_idx   <= 2'd0;
      r_valid <= 4'd0;
      r_fail  <= 4'd0;
      r_lock  <= '0;
      r_match <= 1'b0;
      r_mslot <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lock_load)
        r_lock <= LOCK_W'(LOCK_CYCLES);
      else if (w_locked)
        r_lock <= r_lock - LOCK_W'(1);
      case (r_state)
        S_IDLE: begin
          // Program and verify never overlap, so one code register serves both.
          if (prog_req) begin
            r_slot <= prog_slot;
            r_code <= prog_code;
            r_clr  <= prog_clr;
          end else if (ver_req && !w_locked) begin
            r_code <= ver_code;
            r_idx  <= 2'd0;
          end
        end
        S_PROG: r_valid[r_slot] <= ~r_clr;
        S_SCAN: begin
          if (w_hit) begin
            r_match <= 1'b1;
            r_mslot <= r_idx;
            r_fail  <= 4'd0;
          end else if (w_last) begin
            r_match <= 1'b0;
            r_mslot <= 2'd0;
            r_fail  <= w_lock_load ? 4'd0 : w_fail_inc;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
